// File: rtl/axc3000_reset_sequencer.sv
// Staged reset controller: merges power-on, debounced button and software
// reset requests, holds every output low, then releases them in index order.
module axc3000_reset_sequencer #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 64,
  parameter int RELEASE_GAP     = 16
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic            btn_n,
  input  logic            sw_rst_req,
  output logic [N_CH-1:0] rst_n,
  output logic            seq_done,
  output logic            btn_db,
  output logic [1:0]      rst_cause
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(RELEASE_GAP + 1);
  localparam int CH_W   = $clog2(N_CH + 1);

  typedef enum logic [1:0] {
    S_ASSERT,
    S_RELEASE,
    S_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic                   w_core_rst_n;
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic                   w_btn_s;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_btn_db;

  state_t                 r_state, w_state_nxt;
  logic [HOLD_W-1:0]      r_hold, w_hold_nxt;
  logic [GAP_W-1:0]       r_gap, w_gap_nxt;
  logic [CH_W-1:0]        r_ch, w_ch_nxt;
  logic [N_CH-1:0]        r_rst_out, w_rst_out_nxt;
  logic                   r_done, w_done_nxt;
  logic [1:0]             r_cause, w_cause_nxt;

  logic                   w_btn_req;
  logic                   w_req;

  // Asynchronous assertion, synchronous release of the internal reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_core_rst_n = r_rst_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_clk or negedge w_core_rst_n) begin
    if (!w_core_rst_n) begin
      r_btn_sync <= '1;
    end else begin
      r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], btn_n};
    end
  end

  assign w_btn_s = r_btn_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_clk or negedge w_core_rst_n) begin
    if (!w_core_rst_n) begin
      r_db_cnt <= '0;
      r_btn_db <= 1'b1;
    end else if (w_btn_s == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt <= '0;
      r_btn_db <= ~r_btn_db;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_btn_req = ~r_btn_db;
  assign w_req     = w_btn_req | sw_rst_req;

  always_ff @(posedge clk_clk or negedge w_core_rst_n) begin
    if (!w_core_rst_n) begin
      r_state   <= S_ASSERT;
      r_hold    <= '0;
      r_gap     <= '0;
      r_ch      <= '0;
      r_rst_out <= '0;
      r_done    <= 1'b0;
      r_cause   <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_gap     <= w_gap_nxt;
      r_ch      <= w_ch_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_done    <= w_done_nxt;
      r_cause   <= w_cause_nxt;
    end
  end

  // A request restarts from ASSERT in every state, so it is handled once up
  // front; this also covers the hold-counter clear while already in ASSERT.
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_gap_nxt     = r_gap;
    w_ch_nxt      = r_ch;
    w_rst_out_nxt = r_rst_out;
    w_done_nxt    = r_done;
    w_cause_nxt   = r_cause;
    if (w_req) begin
      w_state_nxt   = S_ASSERT;
      w_hold_nxt    = '0;
      w_gap_nxt     = '0;
      w_ch_nxt      = '0;
      w_rst_out_nxt = '0;
      w_done_nxt    = 1'b0;
      w_cause_nxt   = w_btn_req ? 2'b01 : 2'b10;
    end else begin
      case (r_state)
        S_ASSERT: begin
          if (r_hold == HOLD_W'(HOLD_CYCLES - 1)) begin
            w_hold_nxt    = '0;
            w_rst_out_nxt = N_CH'(1);
            if (N_CH == 1) begin
              w_state_nxt = S_RUN;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_RELEASE;
            end
          end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
        end
        S_RELEASE: begin
          if (r_gap == GAP_W'(RELEASE_GAP - 1)) begin
            w_gap_nxt     = '0;
            w_rst_out_nxt = N_CH'({r_rst_out, 1'b1});
            w_ch_nxt      = r_ch + CH_W'(1);
            if ((r_ch + CH_W'(1)) == CH_W'(N_CH - 1)) begin
              w_state_nxt = S_RUN;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_gap_nxt = r_gap + GAP_W'(1);
          end
        end
        S_RUN: begin
        end
        default: begin
          w_state_nxt = S_ASSERT;
        end
      endcase
    end
  end

  assign rst_n     = r_rst_out;
  assign seq_done  = r_done;
  assign btn_db    = r_btn_db;
  assign rst_cause = r_cause;

endmodule

// File: tb/tb_axc3000_reset_sequencer.sv
// Self-checking bench for axc3000_reset_sequencer: a timeline model of the
// reset sequence compared every cycle, plus literal timing checks.
module tb_axc3000_reset_sequencer;

  localparam int N_CH = 3;
  localparam int SS   = 2;
  localparam int DBC  = 8;
  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic            clk_clk       = 1'b0;
  logic            reset_reset_n = 1'b0;
  logic            btn_n         = 1'b1;
  logic            sw_rst_req    = 1'b0;
  logic [N_CH-1:0] rst_n;
  logic            seq_done;
  logic            btn_db;
  logic [1:0]      rst_cause;

  always #20 clk_clk = ~clk_clk;

  axc3000_reset_sequencer #(
    .N_CH            (N_CH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DBC),
    .HOLD_CYCLES     (HOLD),
    .RELEASE_GAP     (GAP)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .btn_n         (btn_n),
    .sw_rst_req    (sw_rst_req),
    .rst_n         (rst_n),
    .seq_done      (seq_done),
    .btn_db        (btn_db),
    .rst_cause     (rst_cause)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t counts request-free active edges since the sequence started;
  // rst_n[k] is released once m_t reaches HOLD + k*GAP.
  int         m_rel   = 0;
  int         m_t     = 0;
  int         m_dbcnt = 0;
  logic       m_db    = 1'b1;
  logic [1:0] m_cause = 2'b00;
  logic       m_bs;
  logic       m_bsync[$];

  function automatic logic [N_CH-1:0] m_rst();
    logic [N_CH-1:0] v;
    v = '0;
    for (int k = 0; k < N_CH; k++)
      if (m_t >= HOLD + k * GAP) v[k] = 1'b1;
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk_clk or negedge reset_reset_n);
      if (!reset_reset_n) begin
        m_rel   = 0;
        m_t     = 0;
        m_cause = 2'b00;
        m_db    = 1'b1;
        m_dbcnt = 0;
        m_bsync.delete();
        for (int i = 0; i < SS; i++) m_bsync.push_back(1'b1);
      end else if (m_rel < SS) begin
        m_rel++;
      end else begin
        if (!m_db || sw_rst_req) begin
          m_t     = 0;
          m_cause = !m_db ? 2'b01 : 2'b10;
        end else if (m_t < 100000) begin
          m_t++;
        end
        m_bs = m_bsync.pop_front();
        m_bsync.push_back(btn_n);
        if (m_bs == m_db) begin
          m_dbcnt = 0;
        end else begin
          m_dbcnt++;
          if (m_dbcnt == DBC) begin
            m_db    = ~m_db;
            m_dbcnt = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_clk);
      chk("rst_n", rst_n, m_rst());
      chk("seq_done", seq_done, (m_t >= HOLD + (N_CH - 1) * GAP) ? 1 : 0);
      chk("btn_db", btn_db, m_db);
      chk("rst_cause", rst_cause, m_cause);
    end
  end

  int rise[N_CH];
  int done_at;
  int db_at;

  // Edge numbers (1 = first posedge after the call) of first high values.
  task automatic measure(input int max_edges);
    for (int k = 0; k < N_CH; k++) rise[k] = 0;
    done_at = 0;
    db_at   = 0;
    for (int n = 1; n <= max_edges; n++) begin
      @(posedge clk_clk);
      #1;
      for (int k = 0; k < N_CH; k++)
        if (rst_n[k] && rise[k] == 0) rise[k] = n;
      if (seq_done && done_at == 0) done_at = n;
      if (btn_db && db_at == 0) db_at = n;
    end
  endtask

  task automatic sw_pulse();
    @(negedge clk_clk);
    sw_rst_req = 1'b1;
    @(negedge clk_clk);
    sw_rst_req = 1'b0;
  endtask

  initial begin
    int db_fall;
    int rst_fall;
    int found;
    int len;

    // Power-on
    repeat (5) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    measure(12);
    chk("po_rise0", rise[0], 6);
    chk("po_rise1", rise[1], 8);
    chk("po_rise2", rise[2], 10);
    chk("po_done", done_at, 10);
    chk("po_cause", rst_cause, 2'b00);

    // Bouncy button
    for (int i = 0; i < 10; i++) begin
      repeat (3) @(negedge clk_clk);
      btn_n = ~btn_n;
    end
    @(negedge clk_clk);
    btn_n = 1'b1;
    repeat (15) @(negedge clk_clk);
    chk("bounce_db", btn_db, 1'b1);
    chk("bounce_rst", rst_n, 3'b111);

    // Held button, with a simultaneous software pulse while held
    @(negedge clk_clk);
    btn_n    = 1'b0;
    db_fall  = 0;
    rst_fall = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_clk);
      #1;
      if (!btn_db && db_fall == 0) db_fall = n;
      if (rst_n == 3'b000 && rst_fall == 0) rst_fall = n;
    end
    chk("held_db_fall", db_fall, 10);
    chk("held_rst_fall", rst_fall, 11);
    sw_pulse();
    @(negedge clk_clk);
    chk("both_cause", rst_cause, 2'b01);
    repeat (16) @(negedge clk_clk);
    btn_n = 1'b1;
    measure(30);
    chk("held_db_rise", db_at, 10);
    chk("held_rise0", rise[0] - db_at, 4);
    chk("held_rise1", rise[1] - db_at, 6);
    chk("held_rise2", rise[2] - db_at, 8);
    chk("held_cause", rst_cause, 2'b01);

    // Software pulse in RUN
    @(negedge clk_clk);
    sw_rst_req = 1'b1;
    @(posedge clk_clk);
    #1;
    chk("sw_rst", rst_n, 3'b000);
    chk("sw_done", seq_done, 1'b0);
    @(negedge clk_clk);
    sw_rst_req = 1'b0;
    measure(12);
    chk("sw_rise0", rise[0], 4);
    chk("sw_rise1", rise[1], 6);
    chk("sw_rise2", rise[2], 8);
    chk("sw_cause", rst_cause, 2'b10);

    // Abort mid-release
    sw_pulse();
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      @(posedge clk_clk);
      #1;
      if (rst_n == 3'b001) found = 1;
    end
    chk("abort_reach001", found, 1);
    @(negedge clk_clk);
    sw_rst_req = 1'b1;
    @(posedge clk_clk);
    #1;
    chk("abort_rst", rst_n, 3'b000);
    @(negedge clk_clk);
    sw_rst_req = 1'b0;
    measure(12);
    chk("abort_rise0", rise[0], 4);
    chk("abort_rise2", rise[2], 8);

    // Asynchronous reset in RUN
    @(posedge clk_clk);
    #7;
    reset_reset_n = 1'b0;
    #1;
    chk("async_rst", rst_n, 3'b000);
    chk("async_done", seq_done, 1'b0);
    chk("async_cause", rst_cause, 2'b00);
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    measure(12);
    chk("async_rise0", rise[0], 6);
    chk("async_rise2", rise[2], 10);

    // Randomised traffic, checked every cycle by the model
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0, 1: repeat ($urandom_range(1, 20)) @(negedge clk_clk);
        2: sw_pulse();
        3: begin
          len = $urandom_range(1, 25);
          for (int c = 0; c < len; c++) begin
            @(negedge clk_clk);
            btn_n      = 1'b0;
            sw_rst_req = ($urandom_range(0, 7) == 0);
          end
          @(negedge clk_clk);
          btn_n      = 1'b1;
          sw_rst_req = 1'b0;
        end
        4: begin
          len = $urandom_range(4, 30);
          for (int c = 0; c < len; c++) begin
            @(negedge clk_clk);
            btn_n = 1'($urandom_range(0, 1));
          end
          @(negedge clk_clk);
          btn_n = 1'b1;
        end
        default: begin
          if ($urandom_range(0, 2) == 0) begin
            @(posedge clk_clk);
            #7;
            reset_reset_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk_clk);
            reset_reset_n = 1'b1;
          end
        end
      endcase
    end
    btn_n      = 1'b1;
    sw_rst_req = 1'b0;
    repeat (40) @(negedge clk_clk);
    chk("final_rst", rst_n, 3'b111);
    chk("final_done", seq_done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
